// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus card-memory posted-write buffer.
// The write FIFO holds wbuf_entry_t records; the downstream sequencer walks wbuf_state_t.
package nubus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } wbuf_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wbuf_entry_t;

   localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;
   localparam int          ENTRY_W     = $bits(wbuf_entry_t);

endpackage

// File: rtl/nubus_sync_fifo.sv
// Single-clock FIFO with a combinational head output, used as the posted-write queue.
// Pointers carry one extra wrap bit so level = wptr - rptr distinguishes full from empty.
module nubus_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 68
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr_reg;
   logic [AW:0]  rptr_reg;
   logic         pop_ok;
   logic         push_ok;

   assign level   = wptr_reg - rptr_reg;
   assign empty   = (wptr_reg == rptr_reg);
   assign full    = (level == FULL_LEVEL);
   // A push into a full queue is legal when the head leaves in the same cycle.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rptr_reg[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg <= '0;
         rptr_reg <= '0;
      end else begin
         if (push_ok) wptr_reg <= wptr_reg + 1'b1;
         if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr_reg[AW-1:0]] <= din;
   end

endmodule

// File: rtl/nubus_mem_wbuf.sv
// Posted-write buffer between the NuBus slave memory port and card memory.
// Writes complete once queued; reads wait for the queue to drain and are bounded by a timeout.
module nubus_mem_wbuf
   import nubus_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                   nub_clkn,
   input  logic                   nub_resetn,
   input  logic                   s_valid,
   input  logic [31:0]            s_addr,
   input  logic [31:0]            s_wdata,
   input  logic [3:0]             s_write,
   output logic                   s_ready,
   output logic [31:0]            s_rdata,
   output logic                   m_valid,
   output logic [31:0]            m_addr,
   output logic [31:0]            m_wdata,
   output logic [3:0]             m_write,
   input  logic                   m_ready,
   input  logic [31:0]            m_rdata,
   output logic [$clog2(DEPTH):0] wbuf_level,
   output logic                   rd_err
);

   localparam int              LW  = $clog2(DEPTH) + 1;
   localparam int              CW  = $clog2(RD_TIMEOUT + 1);
   localparam logic [CW-1:0]   TMO = CW'(RD_TIMEOUT);

   logic          nub_clk;
   wbuf_state_t   state_reg;
   wbuf_state_t   state_next;
   wbuf_entry_t   fifo_din;
   wbuf_entry_t   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          last_entry;

   logic          rd_pend_reg;
   logic [31:0]   rd_addr_reg;
   logic          ack_hold_reg;
   logic          s_ready_reg;
   logic          rd_err_reg;
   logic [31:0]   s_rdata_reg;
   logic [CW-1:0] rd_cnt_reg;
   logic [CW-1:0] rd_cnt_inc;

   logic          s_take;
   logic          rd_take;
   logic          rd_ok;
   logic          rd_tmo;
   logic          rd_done;

   // Bus flops switch on the falling edge of nub_clkn.
   assign nub_clk = ~nub_clkn;

   // Upstream holds s_valid past our pulse; the pulse cycle and the one after are ignored.
   assign s_take     = s_valid & ~s_ready_reg & ~ack_hold_reg & ~rd_pend_reg;
   assign pop        = (state_reg == WR) & m_ready;
   assign push       = s_take & (s_write != 4'b0000) & (~fifo_full | pop);
   assign rd_take    = s_take & (s_write == 4'b0000);
   assign last_entry = (wbuf_level == LW'(1));

   assign rd_cnt_inc = (rd_cnt_reg == TMO) ? rd_cnt_reg : rd_cnt_reg + 1'b1;
   assign rd_ok      = (state_reg == RD) & m_ready;
   assign rd_tmo     = (state_reg == RD) & ~m_ready & (rd_cnt_inc == TMO);
   assign rd_done    = rd_ok | rd_tmo;

   assign fifo_din = '{addr: s_addr, data: s_wdata, be: s_write};

   nubus_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (nub_clk),
      .rst_n (nub_resetn),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (wbuf_level)
   );

   always_ff @(posedge nub_clk or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      m_valid    = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_write    = '0;
      unique case (state_reg)
         IDLE: begin
            if (!fifo_empty)      state_next = WR;
            else if (rd_pend_reg) state_next = RD;
         end
         WR: begin
            m_valid = 1'b1;
            m_addr  = head.addr;
            m_wdata = head.data;
            m_write = head.be;
            // Stay in WR for back-to-back pops while anything is (or is being) queued.
            if (m_ready && last_entry && !push) state_next = IDLE;
         end
         RD: begin
            m_valid = 1'b1;
            m_addr  = rd_addr_reg;
            if (rd_done) state_next = RESP;
         end
         RESP: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge nub_clk or negedge nub_resetn) begin
      if (!nub_resetn) begin
         s_ready_reg  <= 1'b0;
         ack_hold_reg <= 1'b0;
         rd_err_reg   <= 1'b0;
         s_rdata_reg  <= '0;
         rd_pend_reg  <= 1'b0;
         rd_addr_reg  <= '0;
         rd_cnt_reg   <= '0;
      end else begin
         s_ready_reg  <= push | rd_done;
         ack_hold_reg <= s_ready_reg;
         rd_err_reg   <= rd_tmo;

         if (rd_ok)       s_rdata_reg <= m_rdata;
         else if (rd_tmo) s_rdata_reg <= RD_ERR_DATA;

         if (rd_take) begin
            rd_pend_reg <= 1'b1;
            rd_addr_reg <= s_addr;
         end else if (state_reg == RESP) begin
            rd_pend_reg <= 1'b0;
         end

         // Held at zero outside RD, so every read starts with a fresh count.
         if (state_reg == RD) rd_cnt_reg <= rd_cnt_inc;
         else                 rd_cnt_reg <= '0;
      end
   end

   assign s_ready = s_ready_reg;
   assign s_rdata = s_rdata_reg;
   assign rd_err  = rd_err_reg;

endmodule

// File: tb/tb_nubus_mem_wbuf.sv
// Scoreboard bench for nubus_mem_wbuf: stimulus queues expected transfers, a monitor
// compares downstream transfers and upstream completions as the DUT presents them.
module tb_nubus_mem_wbuf;

   logic        nub_clkn;
   logic        nub_resetn;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_write;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_write;
   logic        m_ready;
   logic [31:0] m_rdata;
   logic [2:0]  wbuf_level;
   logic        rd_err;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } mexp_t;

   typedef struct {
      logic        rd;
      logic [31:0] data;
      logic        err;
   } sexp_t;

   mexp_t exp_m[$];
   sexp_t exp_s[$];
   int    total = 0;
   int    bad   = 0;

   nubus_mem_wbuf #(.DEPTH(4), .RD_TIMEOUT(255)) dut (
      .nub_clkn   (nub_clkn),
      .nub_resetn (nub_resetn),
      .s_valid    (s_valid),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_write    (s_write),
      .s_ready    (s_ready),
      .s_rdata    (s_rdata),
      .m_valid    (m_valid),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_write    (m_write),
      .m_ready    (m_ready),
      .m_rdata    (m_rdata),
      .wbuf_level (wbuf_level),
      .rd_err     (rd_err)
   );

   initial nub_clkn = 1'b1;
   always #5 nub_clkn = ~nub_clkn;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: samples on the rising edge of nub_clkn, halfway between active edges.
   initial begin
      mexp_t me;
      sexp_t se;
      forever begin
         @(posedge nub_clkn);
         if (nub_resetn) begin
            if (m_valid && m_ready) begin
               if (exp_m.size() == 0) begin
                  total++; bad++;
                  $display("FAIL m_xfer_unexpected: got addr=%h want none", m_addr);
               end else begin
                  me = exp_m.pop_front();
                  check("m_addr", m_addr, me.addr);
                  check("m_write", 32'(m_write), 32'(me.be));
                  if (me.be != 4'b0000) check("m_wdata", m_wdata, me.data);
                  $display("xfer m addr=%h be=%h wdata=%h", m_addr, m_write, m_wdata);
               end
            end
            if (s_ready) begin
               if (exp_s.size() == 0) begin
                  total++; bad++;
                  $display("FAIL s_ready_unexpected: got pulse want none");
               end else begin
                  se = exp_s.pop_front();
                  check("rd_err", 32'(rd_err), 32'(se.err));
                  if (se.rd) check("s_rdata", s_rdata, se.data);
                  $display("done s rd=%0d rdata=%h err=%0d", se.rd, s_rdata, rd_err);
               end
            end else begin
               check("rd_err_idle", 32'(rd_err), 32'd0);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge nub_clkn);
         #1;
      end
   endtask

   task automatic wait_ready(input int budget, output int n);
      int seen;
      seen = 0;
      n = 0;
      while (seen == 0 && n < budget) begin
         @(posedge nub_clkn);
         n++;
         if (s_ready) seen = 1;
      end
      if (seen == 0) begin
         total++; bad++;
         $display("FAIL s_ready_timeout: got none in %0d cycles want pulse", budget);
      end
      @(negedge nub_clkn);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int hold, output int n);
      mexp_t me;
      sexp_t se;
      me.addr = a; me.data = d; me.be = be;
      se.rd = 1'b0; se.data = '0; se.err = 1'b0;
      exp_m.push_back(me);
      exp_s.push_back(se);
      s_valid = 1'b1; s_addr = a; s_wdata = d; s_write = be;
      wait_ready(10, n);
      if (hold > 0) tick(hold);
      s_valid = 1'b0;
      tick(1);
   endtask

   task automatic push_read(input logic [31:0] a, input logic [31:0] rdata, input logic err,
                            input int expect_xfer);
      mexp_t me;
      sexp_t se;
      me.addr = a; me.data = '0; me.be = 4'b0000;
      se.rd = 1'b1; se.data = rdata; se.err = err;
      if (expect_xfer != 0) exp_m.push_back(me);
      exp_s.push_back(se);
      s_valid = 1'b1; s_addr = a; s_wdata = '0; s_write = 4'b0000;
   endtask

   initial begin
      int n;
      int cnt;
      int seen;
      s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_write = '0;
      m_ready = 1'b0; m_rdata = '0;
      nub_resetn = 1'b1;
      #1 nub_resetn = 1'b0;
      #2;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_s_rdata", s_rdata, 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_write", 32'(m_write), 32'd0);
      check("rst_level", 32'(wbuf_level), 32'd0);
      check("rst_rd_err", 32'(rd_err), 32'd0);
      tick(2);
      nub_resetn = 1'b1;
      tick(2);

      // 1: single write, memory always ready
      m_ready = 1'b1;
      req(32'h10, 32'h1122_3344, 4'hF, 0, n);
      check("t1_latency", 32'(n), 32'd2);
      tick(2);
      check("t1_level", 32'(wbuf_level), 32'd0);
      check("t1_m_valid", 32'(m_valid), 32'd0);

      // 2: fill the queue, fifth write stalls until a pop
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), (i == 1) ? 4'h3 : 4'hF, 0, n);
         check("t2_latency", 32'(n), 32'd2);
      end
      check("t2_level_full", 32'(wbuf_level), 32'd4);
      begin
         mexp_t me;
         sexp_t se;
         me.addr = 32'h210; me.data = 32'hA5A5_0004; me.be = 4'hC;
         se.rd = 1'b0; se.data = '0; se.err = 1'b0;
         exp_m.push_back(me);
         exp_s.push_back(se);
      end
      s_valid = 1'b1; s_addr = 32'h210; s_wdata = 32'hA5A5_0004; s_write = 4'hC;
      seen = 0;
      repeat (4) begin
         @(posedge nub_clkn);
         if (s_ready) seen = 1;
      end
      tick(1);
      check("t2_stall_no_ack", 32'(seen), 32'd0);
      check("t2_level_stalled", 32'(wbuf_level), 32'd4);
      m_ready = 1'b1;
      wait_ready(10, n);
      s_valid = 1'b0;
      check("t2_ack_after_pop", 32'(n), 32'd2);
      tick(6);
      check("t2_level_drained", 32'(wbuf_level), 32'd0);

      // 3: read queued behind three posted writes
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req(32'h300 + 32'(i * 4), 32'h3300_0000 + 32'(i), 4'hF, 0, n);
      end
      push_read(32'h10, 32'hCAFE_BABE, 1'b0, 1);
      tick(5);
      check("t3_head_is_write", 32'(m_write), 32'hF);
      check("t3_head_addr", m_addr, 32'h300);
      m_ready = 1'b1;
      m_rdata = 32'hCAFE_BABE;
      wait_ready(30, n);
      s_valid = 1'b0;
      check("t3_read_latency", 32'(n), 32'd6);
      check("t3_rdata_held", s_rdata, 32'hCAFE_BABE);
      m_ready = 1'b0;
      m_rdata = 32'h0;
      tick(2);

      // 4: read that memory never answers
      push_read(32'h20, 32'hFFFF_FFFF, 1'b1, 0);
      cnt = 0; n = 0; seen = 0;
      while (seen == 0 && n < 400) begin
         @(posedge nub_clkn);
         n++;
         if (m_valid && m_write == 4'b0000) cnt++;
         if (s_ready) seen = 1;
      end
      if (seen == 0) begin
         total++; bad++;
         $display("FAIL t4_timeout_ack: got none in 400 cycles want pulse");
      end
      check("t4_rd_wait_cycles", 32'(cnt), 32'd255);
      tick(1);
      s_valid = 1'b0;
      check("t4_m_valid_idle", 32'(m_valid), 32'd0);
      check("t4_s_rdata_err", s_rdata, 32'hFFFF_FFFF);
      tick(2);

      // 5: s_valid held one cycle past s_ready must not double-push
      req(32'h500, 32'h55AA_55AA, 4'h5, 1, n);
      check("t5_latency", 32'(n), 32'd2);
      tick(2);
      check("t5_level_one", 32'(wbuf_level), 32'd1);
      m_ready = 1'b1;
      tick(4);
      check("t5_level_drained", 32'(wbuf_level), 32'd0);
      m_ready = 1'b0;

      // 6: reset while writing with two entries buffered
      req(32'h600, 32'h6600_0000, 4'hF, 0, n);
      req(32'h604, 32'h6600_0001, 4'hF, 0, n);
      check("t6_level_pre", 32'(wbuf_level), 32'd2);
      check("t6_m_valid_pre", 32'(m_valid), 32'd1);
      #2 nub_resetn = 1'b0;
      #1;
      check("t6_s_ready", 32'(s_ready), 32'd0);
      check("t6_s_rdata", s_rdata, 32'd0);
      check("t6_m_valid", 32'(m_valid), 32'd0);
      check("t6_m_addr", m_addr, 32'd0);
      check("t6_m_wdata", m_wdata, 32'd0);
      check("t6_m_write", 32'(m_write), 32'd0);
      check("t6_level", 32'(wbuf_level), 32'd0);
      check("t6_rd_err", 32'(rd_err), 32'd0);
      exp_m.delete();
      tick(2);
      nub_resetn = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(posedge nub_clkn);
         if (m_valid) cnt++;
      end
      tick(1);
      check("t6_no_m_valid", 32'(cnt), 32'd0);
      check("t6_level_after", 32'(wbuf_level), 32'd0);

      check("sb_m_empty", 32'(exp_m.size()), 32'd0);
      check("sb_s_empty", 32'(exp_s.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
